// File: rtl/wavefront_tile_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wavefront_pkg
//  Description : Shared types and helpers for the wavefront tile scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package wavefront_pkg;

    // Scheduler phases for one tile
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } sched_state_t;

    // Cycles needed for the last product to cross an n x n array
    function automatic int drain_cycles(input int n);
        return 2 * n - 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wavefront_tile_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : wavefront_tile_sched_if
//  Description : Valid/ready vector stream from the operand buffer.
//  Revision    : 1.0  initial release
// ============================================================================
interface wavefront_tile_sched_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_a [0:N-1];

    modport master (output in_valid, output in_a, input  in_ready);
    modport slave  (input  in_valid, input  in_a, output in_ready);
endinterface

`default_nettype wire

// File: rtl/wavefront_tile_sched_skew.sv
`default_nettype none
// ============================================================================
//  Module      : skew_line_rst
//  Description : Resettable W-bit shift register of depth D (D >= 1).
//  Revision    : 1.0  initial release
// ============================================================================
module skew_line_rst #(
    parameter int W = 9,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    logic [W-1:0] stage_q [0:D-1];
    logic [W-1:0] stage_d [0:D-1];

    // Next value of each stage: head takes the input, the rest shift along
    always_comb begin
        stage_d[0] = din;
        for (int s = 1; s < D; s++) begin
            stage_d[s] = stage_q[s-1];
        end
    end

    // Stage registers; reset flushes the line to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < D; s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < D; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end
    end

    assign dout = stage_q[D-1];

endmodule

`default_nettype wire

// File: rtl/wavefront_tile_sched.sv
`default_nettype none
// ============================================================================
//  Module      : wavefront_tile_sched
//  Description : Sequences one tile of an N-lane systolic array: clear,
//                feed K skewed vectors, drain 2N-1 cycles, pulse done.
//  Revision    : 1.0  initial release
// ============================================================================
module wavefront_tile_sched
    import wavefront_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int K_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [K_WIDTH-1:0]      k_len,
    wavefront_tile_sched_if.slave   in_if,
    output logic [DATA_WIDTH-1:0]   arr_din [0:N-1],
    output logic [N-1:0]            lane_valid,
    output logic                    arr_clr,
    output logic                    busy,
    output logic                    done
);
    localparam int DRAIN_LEN = drain_cycles(N);
    localparam int DCW       = $clog2(2 * N);

    sched_state_t        state_q, state_d;
    logic [K_WIDTH-1:0]  k_reg_q, k_reg_d;
    logic [K_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DCW-1:0]      drain_cnt_q, drain_cnt_d;
    logic                accept;
    logic [DATA_WIDTH:0] slot     [0:N-1];   // {valid, data} entering each lane
    logic [DATA_WIDTH:0] lane_out [0:N-1];

    // Next-state, counters and phase outputs
    always_comb begin
        state_d         = state_q;
        k_reg_d         = k_reg_q;
        beat_cnt_d      = beat_cnt_q;
        drain_cnt_d     = drain_cnt_q;
        in_if.in_ready  = 1'b0;
        arr_clr         = 1'b0;
        busy            = 1'b1;
        done            = 1'b0;
        accept          = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    k_reg_d    = k_len;
                    beat_cnt_d = '0;
                    state_d    = CLEAR;
                end
            end
            CLEAR: begin
                arr_clr     = 1'b1;
                drain_cnt_d = '0;
                state_d     = (k_reg_q == '0) ? DONE : FEED;
            end
            FEED: begin
                in_if.in_ready = 1'b1;
                accept         = in_if.in_valid;
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + K_WIDTH'(1);
                    // Compare before incrementing so k_len = max never wraps
                    if (beat_cnt_q == k_reg_q - K_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + DCW'(1);
                if (drain_cnt_q == DCW'(DRAIN_LEN - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Feed slot: accepted beat carries data with valid, everything else is a bubble
    always_comb begin
        for (int i = 0; i < N; i++) begin
            slot[i] = accept ? {1'b1, in_if.in_a[i]} : '0;
        end
    end

    // Scheduler state; reset aborts any tile in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_reg_q     <= '0;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            k_reg_q     <= k_reg_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // Lane i is delayed 1+i cycles so the grid receives a ready-made wavefront
    generate
        for (genvar i = 0; i < N; i++) begin : g_lane
            skew_line_rst #(
                .W (DATA_WIDTH + 1),
                .D (i + 1)
            ) u_skew (
                .clk   (clk),
                .rst_n (rst_n),
                .din   (slot[i]),
                .dout  (lane_out[i])
            );
            assign arr_din[i]    = lane_out[i][DATA_WIDTH-1:0];
            assign lane_valid[i] = lane_out[i][DATA_WIDTH];
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_wavefront_tile_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wavefront_tile_sched
//  Description : Self-checking bench for wavefront_tile_sched with a
//                cycle-timeline reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wavefront_tile_sched;
    localparam int DW   = 8;
    localparam int N    = 4;
    localparam int KW   = 8;
    localparam int MAXC = 1024;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic [DW-1:0] arr_din [0:N-1];
    logic [N-1:0]  lane_valid;
    logic          arr_clr, busy, done;

    wavefront_tile_sched_if #(.DATA_WIDTH(DW), .N(N)) in_if ();

    wavefront_tile_sched #(.DATA_WIDTH(DW), .N(N), .K_WIDTH(KW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .k_len      (k_len),
        .in_if      (in_if),
        .arr_din    (arr_din),
        .lane_valid (lane_valid),
        .arr_clr    (arr_clr),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus plan and predicted timeline (cycle 0 = start presented)
    bit            vpat  [MAXC];
    logic [DW-1:0] bdat  [256][N];
    bit            e_busy[MAXC];
    bit            e_rdy [MAXC];
    bit            e_clr [MAXC];
    bit            e_done[MAXC];
    bit            sv    [MAXC];
    logic [DW-1:0] sd    [MAXC][N];
    int            bidx  [MAXC];
    int            dcyc;
    int            acc_cnt, done_cnt;
    int            lv_cnt [N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv, input int cyc);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
        end
    endtask

    // Timeline from the tile rules: clear in cycle 1, beats from cycle 2 on
    // whenever valid is offered, 2N-1 drain cycles after the last beat, then done.
    task automatic build_model(input int k);
        int c, acc;
        for (int t = 0; t < MAXC; t++) begin
            e_busy[t] = 0; e_rdy[t] = 0; e_clr[t] = 0; e_done[t] = 0;
            sv[t] = 0; bidx[t] = -1;
            for (int i = 0; i < N; i++) sd[t][i] = '0;
        end
        bidx[0] = 0; bidx[1] = 0;
        e_busy[1] = 1; e_clr[1] = 1;
        if (k == 0) begin
            dcyc = 2;
        end else begin
            c = 2; acc = 0;
            while (acc < k) begin
                e_busy[c] = 1; e_rdy[c] = 1; bidx[c] = acc;
                if (vpat[c]) begin
                    sv[c] = 1;
                    for (int i = 0; i < N; i++) sd[c][i] = bdat[acc][i];
                    acc++;
                end
                c++;
            end
            for (int j = 0; j < 2*N-1; j++) e_busy[c+j] = 1;
            dcyc = c + 2*N - 1;
        end
        e_busy[dcyc] = 1; e_done[dcyc] = 1;
    endtask

    task automatic check_all_zero(input string tag, input int cyc);
        chk({tag, "_busy"},  busy,            0, cyc);
        chk({tag, "_done"},  done,            0, cyc);
        chk({tag, "_clr"},   arr_clr,         0, cyc);
        chk({tag, "_rdy"},   in_if.in_ready,  0, cyc);
        chk({tag, "_lv"},    lane_valid,      0, cyc);
        for (int i = 0; i < N; i++) chk($sformatf("%s_din%0d", tag, i), arr_din[i], 0, cyc);
    endtask

    task automatic run_tile(input int k, input int abort_at, input bit hold);
        logic [N-1:0]  ev;
        logic [DW-1:0] ed;
        build_model(k);
        acc_cnt = 0; done_cnt = 0;
        for (int i = 0; i < N; i++) lv_cnt[i] = 0;
        for (int c = 0; c <= dcyc; c++) begin
            @(posedge clk); #1;
            start = (c == 0) ? 1'b1 : hold;
            if (c == 0) k_len = KW'(k);
            else if (c == 3) k_len = KW'(k ^ 'h5A);
            if (bidx[c] >= 0) begin
                in_if.in_valid = vpat[c];
                for (int i = 0; i < N; i++) in_if.in_a[i] = bdat[bidx[c]][i];
            end else begin
                in_if.in_valid = 1'b0;
                for (int i = 0; i < N; i++) in_if.in_a[i] = '0;
            end
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("abort", c);
                repeat (2) begin
                    @(negedge clk);
                    chk("abort_nodone", done, 0, c);
                    chk("abort_lv",     lane_valid, 0, c);
                end
                start = 1'b0;
                in_if.in_valid = 1'b0;
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            chk("busy",     busy,           e_busy[c], c);
            chk("done",     done,           e_done[c], c);
            chk("arr_clr",  arr_clr,        e_clr[c],  c);
            chk("in_ready", in_if.in_ready, e_rdy[c],  c);
            for (int i = 0; i < N; i++) begin
                ev[i] = (c - 1 - i >= 0) ? sv[c-1-i] : 1'b0;
                ed    = (c - 1 - i >= 0) ? sd[c-1-i][i] : '0;
                chk($sformatf("arr_din%0d", i), arr_din[i], ed, c);
                lv_cnt[i] += int'(lane_valid[i]);
            end
            chk("lane_valid", lane_valid, ev, c);
            if (in_if.in_valid && in_if.in_ready) acc_cnt++;
            done_cnt += int'(done);
        end
    endtask

    task automatic plan_all_valid();
        for (int t = 0; t < MAXC; t++) vpat[t] = 1;
        for (int b = 0; b < 256; b++)
            for (int i = 0; i < N; i++) bdat[b][i] = DW'(10*b + i);
    endtask

    task automatic plan_random();
        for (int t = 0; t < MAXC; t++) vpat[t] = (t >= 800) ? 1'b1 : 1'($urandom_range(0, 1));
        for (int b = 0; b < 256; b++)
            for (int i = 0; i < N; i++) bdat[b][i] = DW'($urandom);
    endtask

    initial begin
        in_if.in_valid = 1'b0;
        for (int i = 0; i < N; i++) in_if.in_a[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check_all_zero("reset", 0);
        rst_n = 1'b1;

        // T1: K=3, continuous valid
        plan_all_valid();
        run_tile(3, -1, 0);

        // T2: two bubbles in cycles 3-4
        plan_all_valid();
        vpat[3] = 0; vpat[4] = 0;
        run_tile(3, -1, 0);

        // T3: empty tile
        plan_all_valid();
        run_tile(0, -1, 0);
        chk("t3_lv_total", lv_cnt[0] + lv_cnt[1] + lv_cnt[2] + lv_cnt[3], 0, 0);

        // T4: reset in cycle 4 of T1, then full T1 again
        plan_all_valid();
        run_tile(3, 4, 0);
        run_tile(3, -1, 0);
        chk("t4_done_once", done_cnt, 1, 0);

        // T5: start held through the tile, back-to-back second tile
        plan_all_valid();
        run_tile(3, -1, 1);
        plan_random();
        run_tile(5, -1, 0);

        // Small random tiles
        repeat (4) begin
            plan_random();
            run_tile($urandom_range(1, 12), -1, 0);
        end

        // T6: K=255, random valid
        plan_random();
        run_tile(255, -1, 0);
        chk("t6_beats", acc_cnt, 255, 0);
        for (int i = 0; i < N; i++) chk($sformatf("t6_lv%0d", i), lv_cnt[i], 255, 0);
        chk("t6_done", done_cnt, 1, 0);

        @(negedge clk);
        chk("end_idle", busy, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
